// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//   Loadable down-counter / timer.
//   - A start value is accepted over a valid/ready load handshake.
//   - The count decrements on each enabled clock.
//   - tc pulses for one cycle at terminal count.
//   - done is a level that holds until it is acknowledged or a new load arrives.
//   Intended as the shared delay/timeout engine for sequencing logic.
//
// Optional feature (compile-time macro AUTO_RELOAD_EN):
//   When defined, the load value is also kept in a reload register.
//   At terminal count the counter reloads, stays in RUN and pulses tc, giving a
//   periodic tick. It then runs until abort or reset, and done stays low.
//   A load of 0 still goes straight to DONE.
//   When undefined, the counter is one-shot (RUN -> DONE).
//
// Parameters
//   WIDTH     bit width of ld_val and count
//
// Ports
//   clk       system clock, all logic on posedge
//   rst_n     synchronous active-low reset, priority over everything
//   ld_valid  load request, ld_val valid while high
//   ld_ready  load can be accepted (IDLE or DONE)
//   ld_val    unsigned start value
//   en        count enable
//   abort     cancel a running count (ignored outside RUN)
//   ack       clear done (a simultaneous load wins)
//   count     current count (registered)
//   busy      high in RUN
//   tc        one-cycle terminal-count pulse (registered)
//   done      high in DONE
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             abort,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg, reload_next;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            tc_reg     <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            tc_reg     <= tc_next;
`ifdef AUTO_RELOAD_EN
            reload_reg <= reload_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        tc_next     = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_next = reload_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE: begin
                // A load takes priority over ack when both arrive in DONE.
                if (ld_valid) begin
`ifdef AUTO_RELOAD_EN
                    reload_next = ld_val;
`endif
                    if (ld_val != '0) begin
                        count_next = ld_val;
                        state_next = S_RUN;
                    end else begin
                        // A zero load is an immediate terminal count.
                        count_next = '0;
                        state_next = S_DONE;
                        tc_next    = 1'b1;
                    end
                end else if (state_reg == S_DONE && ack) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    count_next = '0;
                    state_next = S_IDLE;
                end else if (en) begin
                    if (count_reg > WIDTH'(1)) begin
                        count_next = count_reg - WIDTH'(1);
                    end else begin
                        // A count of 1 (or 0, unreachable in RUN) terminates,
                        // so the count can never wrap below zero.
                        tc_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                        count_next = reload_reg;
`else
                        count_next = '0;
                        state_next = S_DONE;
`endif
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        count    = count_reg;
        tc       = tc_reg;
        busy     = (state_reg == S_RUN);
        done     = (state_reg == S_DONE);
        ld_ready = (state_reg == S_IDLE) || (state_reg == S_DONE);
    end

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_val;
    logic             en;
    logic             abort;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    int checks = 0;
    int errors = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_val   (ld_val),
        .en       (en),
        .abort    (abort),
        .ack      (ack),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs held across one rising edge + outputs expected after it.
    typedef struct {
        logic             rst_n;
        logic             ld_valid;
        logic [WIDTH-1:0] ld_val;
        logic             en;
        logic             abort;
        logic             ack;
        logic [WIDTH-1:0] exp_count;
        logic             exp_busy;
        logic             exp_tc;
        logic             exp_done;
        logic             exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic lv, input int v,
                                input logic e, input logic ab, input logic ak,
                                input int c, input logic b, input logic t,
                                input logic d, input logic rd);
        vec_t x;
        x.rst_n = r;  x.ld_valid = lv; x.ld_val = WIDTH'(v);
        x.en = e;     x.abort = ab;    x.ack = ak;
        x.exp_count = WIDTH'(c); x.exp_busy = b; x.exp_tc = t;
        x.exp_done = d; x.exp_ready = rd;
        return x;
    endfunction

    // Drive, clock, sample 1 time unit after the edge, compare.
    task automatic step(input vec_t v, input string name);
        rst_n = v.rst_n; ld_valid = v.ld_valid; ld_val = v.ld_val;
        en = v.en; abort = v.abort; ack = v.ack;
        @(posedge clk);
        #1;
        checks++;
        if (count !== v.exp_count || busy !== v.exp_busy || tc !== v.exp_tc ||
            done !== v.exp_done || ld_ready !== v.exp_ready) begin
            errors++;
            $display("FAIL %s: got count=%0d busy=%b tc=%b done=%b ld_ready=%b, want count=%0d busy=%b tc=%b done=%b ld_ready=%b",
                     name, count, busy, tc, done, ld_ready,
                     v.exp_count, v.exp_busy, v.exp_tc, v.exp_done, v.exp_ready);
        end else begin
            $display("ok   %s: count=%0d busy=%b tc=%b done=%b ld_ready=%b",
                     name, count, busy, tc, done, ld_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_val = '0; en = 1'b0; abort = 1'b0; ack = 1'b0;

        //            rst lv  val en ab ak   cnt bsy tc dn rdy
        // reset state
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1));
        // load 5, run to 3, reset mid-RUN (with a load request also present)
        vecs.push_back(mk(1, 1,   5, 1, 0, 0,   5, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 1, 0, 0,   4, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 1, 0, 0,   3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,   7, 1, 1, 1,   0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1));
        // load 1: shortest non-zero run
        vecs.push_back(mk(1, 1,   1, 1, 0, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 1, 0, 0,   0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0,   0, 0, 0, 1,   0, 0, 0, 0, 1));
        // load 255: maximum value
        vecs.push_back(mk(1, 1, 255, 1, 0, 0, 255, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 1, 0, 0, 254, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 1, 1, 0,   0, 0, 0, 0, 1));
        // abort in IDLE is ignored
        vecs.push_back(mk(1, 0,   0, 1, 1, 0,   0, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

`ifndef AUTO_RELOAD_EN
        // Load 3, en=1: 3,2,1,0; tc one cycle; done holds (abort ignored in DONE); ack -> IDLE
        step(mk(1, 1, 3, 1, 0, 0, 3, 1, 0, 0, 0), "t2_load3");
        step(mk(1, 0, 0, 1, 0, 0, 2, 1, 0, 0, 0), "t2_cnt2");
        step(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0), "t2_cnt1");
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1), "t2_tc");
        step(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1), "t2_done_hold");
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "t2_ack");
        // Load 4, en 1,0,1,0,1,1 -> 3,3,2,2,1,0
        step(mk(1, 1, 4, 0, 0, 0, 4, 1, 0, 0, 0), "t3_load4");
        step(mk(1, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0), "t3_e1");
        step(mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0), "t3_e2");
        step(mk(1, 0, 0, 1, 0, 0, 2, 1, 0, 0, 0), "t3_e3");
        step(mk(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0), "t3_e4");
        step(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0), "t3_e5");
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1), "t3_e6_tc");
        // Load 0 while in DONE: done re-set, tc again, busy never high
        step(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1), "t4_load0_in_done");
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1), "t4_tc_drop");
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "t4_ack");
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1), "t4_load0_idle");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "t4_hold");
        // ack + load 2 together in DONE: load wins
        step(mk(1, 1, 2, 0, 0, 1, 2, 1, 0, 0, 0), "t5_ack_load");
        // load request in RUN is ignored
        step(mk(1, 1, 9, 0, 0, 0, 2, 1, 0, 0, 0), "t5_ld_in_run");
        step(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0), "t5_cnt1");
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1), "t5_tc");
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "t5_ack");
        // Load 6, abort at count 2: no tc, no done
        step(mk(1, 1, 6, 1, 0, 0, 6, 1, 0, 0, 0), "t5_load6");
        for (int k = 5; k >= 2; k--) begin
            step(mk(1, 0, 0, 1, 0, 0, k, 1, 0, 0, 0), $sformatf("t5_cnt%0d", k));
        end
        step(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), "t5_abort");
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), "t5_idle");
`else
        // Auto-reload: load 3, tc every 3 enabled edges, done stays 0
        step(mk(1, 1, 3, 1, 0, 0, 3, 1, 0, 0, 0), "ar_load3");
        for (int k = 1; k <= 12; k++) begin
            int c;
            c = 3 - (k % 3);
            step(mk(1, 0, 0, 1, 0, 0, c, 1, (k % 3) == 0, 0, 0),
                 $sformatf("ar_edge%0d", k));
        end
        step(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), "ar_abort");
        for (int k = 0; k < 4; k++) begin
            step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), $sformatf("ar_idle%0d", k));
        end
        // Zero load still terminates in DONE
        step(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1), "ar_load0");
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1), "ar_done_hold");
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "ar_ack");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
